// File: rtl/mixcol_sequencer.sv
// rtl/mixcol_sequencer.sv - AES (Inv)MixColumns column sequencer over one shared GF(2^8) multiplier
module mixcol_sequencer #(
    parameter logic [7:0] RED_POLY = 8'h1B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        inv_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  acc_q, acc_d;
    logic [31:0] out_col_q, out_col_d;
    logic [31:0] col_q, col_d;
    logic        inv_q, inv_d;

    logic [1:0]  row;
    logic [1:0]  col;
    logic [1:0]  coef_idx;
    logic [7:0]  coef;
    logic [7:0]  a_byte;
    logic [7:0]  term;

    // Carry-less 8x8 product folded back into the field from the top bit down.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ (15'(x) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (15'({1'b1, RED_POLY}) << (i - 8));
        end
        return p[7:0];
    endfunction

    // Coefficient row r is the base row rotated right by r, so index = (col - row) mod 4.
    always_comb begin
        row      = cnt_q[3:2];
        col      = cnt_q[1:0];
        coef_idx = col - row;
        a_byte   = col_q[{~col, 3'b000} +: 8];
        coef     = 8'h00;
        if (inv_q) begin
            case (coef_idx)
                2'd0:    coef = 8'h0E;
                2'd1:    coef = 8'h0B;
                2'd2:    coef = 8'h0D;
                default: coef = 8'h09;
            endcase
        end else begin
            case (coef_idx)
                2'd0:    coef = 8'h02;
                2'd1:    coef = 8'h03;
                default: coef = 8'h01;
            endcase
        end
        term = gf_mul(coef, a_byte);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; any unused encoding falls back to IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = in_valid ? ST_MUL : ST_IDLE;
            ST_MUL:  state_d = (cnt_q == 4'd15) ? ST_DONE : ST_MUL;
            ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_MUL) || (state_q == ST_DONE);
        out_col   = out_col_q;
    end

    // Datapath next values: latch on accept, then one multiply-accumulate per MUL cycle.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        out_col_d = out_col_q;
        col_d     = col_q;
        inv_d     = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    col_d = in_col;
                    inv_d = inv_mode;
                    cnt_d = 4'd0;
                    acc_d = 8'h00;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 4'd1;
                if (col == 2'd0) begin
                    acc_d = term;
                end else if (col == 2'd3) begin
                    out_col_d[{~row, 3'b000} +: 8] = acc_q ^ term;
                end else begin
                    acc_d = acc_q ^ term;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= 4'd0;
            acc_q     <= 8'h00;
            out_col_q <= 32'h0;
            col_q     <= 32'h0;
            inv_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            out_col_q <= out_col_d;
            col_q     <= col_d;
            inv_q     <= inv_d;
        end
    end

endmodule

// File: tb/tb_mixcol_sequencer.sv
// tb/tb_mixcol_sequencer.sv - directed self-checking bench for mixcol_sequencer
module tb_mixcol_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_col;
    logic        inv_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int prev_accept = 0;

    mixcol_sequencer #(.RED_POLY(8'h1B)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_col    (in_col),
        .inv_mode  (inv_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs == exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Offer a column and return #1 after the accepting edge.
    task automatic submit(input string tag, input logic [31:0] c, input logic m, input bit flip);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk1({tag, "_in_ready_idle"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_col   = c;
        inv_mode = m;
        @(posedge clk); #1;
        prev_accept = accept_cyc;
        accept_cyc  = cyc;
        in_valid = 1'b0;
        in_col   = $urandom;
        if (flip) inv_mode = ~m;
        chk1({tag, "_busy_mul"}, busy, 1'b1);
        chk1({tag, "_in_ready_mul"}, in_ready, 1'b0);
    endtask

    // Wait for out_valid, check latency and data.
    task automatic wait_result(input string tag, input logic [31:0] exp_v);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chkint({tag, "_latency"}, n, 16);
        chk32({tag, "_out_col"}, out_col, exp_v);
    endtask

    // Complete the output handshake with out_ready high.
    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk1({tag, "_out_valid_after"}, out_valid, 1'b0);
        chk1({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_col    = 32'h0;
        inv_mode  = 1'b0;
        out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_out_col", out_col, 32'h0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Forward vectors, back to back
        submit("fwd0", 32'hDB135345, 1'b0, 1'b0);
        wait_result("fwd0", 32'h8E4DA1BC);
        release_out("fwd0");
        submit("fwd1", 32'hF20A225C, 1'b0, 1'b0);
        chkint("fwd1_ii", accept_cyc - prev_accept, 18);
        wait_result("fwd1", 32'h9FDC589D);
        release_out("fwd1");
        submit("fwd2", 32'hD4D4D4D5, 1'b0, 1'b0);
        chkint("fwd2_ii", accept_cyc - prev_accept, 18);
        wait_result("fwd2", 32'hD5D5D7D6);
        release_out("fwd2");
        submit("fwd3", 32'hC6C6C6C6, 1'b0, 1'b0);
        chkint("fwd3_ii", accept_cyc - prev_accept, 18);
        wait_result("fwd3", 32'hC6C6C6C6);
        release_out("fwd3");

        // Inverse vectors and identity column in both modes
        submit("inv0", 32'h8E4DA1BC, 1'b1, 1'b0);
        wait_result("inv0", 32'hDB135345);
        release_out("inv0");
        submit("inv1", 32'h9FDC589D, 1'b1, 1'b0);
        wait_result("inv1", 32'hF20A225C);
        release_out("inv1");
        submit("id_inv", 32'h01010101, 1'b1, 1'b0);
        wait_result("id_inv", 32'h01010101);
        release_out("id_inv");
        submit("id_fwd", 32'h01010101, 1'b0, 1'b0);
        wait_result("id_fwd", 32'h01010101);
        release_out("id_fwd");

        // Backpressure with input noise while DONE is held
        out_ready = 1'b0;
        submit("bp", 32'hDB135345, 1'b0, 1'b0);
        wait_result("bp", 32'h8E4DA1BC);
        held = out_col;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            in_col   = $urandom;
            inv_mode = ~inv_mode;
            @(posedge clk); #1;
            chk32("bp_hold_out_col", out_col, 32'h8E4DA1BC);
            chk1("bp_hold_out_valid", out_valid, 1'b1);
            chk1("bp_hold_in_ready", in_ready, 1'b0);
        end
        chk32("bp_held_equal", out_col, held);
        in_valid = 1'b0;
        release_out("bp");

        // Reset in the middle of an operation
        submit("abort", 32'hF20A225C, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk32("abort_out_col", out_col, 32'h0);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        submit("post_abort", 32'hDB135345, 1'b0, 1'b0);
        wait_result("post_abort", 32'h8E4DA1BC);
        release_out("post_abort");

        // Mode flipped right after acceptance must not affect the column
        submit("mode_latch", 32'hDB135345, 1'b0, 1'b1);
        wait_result("mode_latch", 32'h8E4DA1BC);
        release_out("mode_latch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
